// File: rtl/jtag_pkg.sv
// Shared types and constants for the TAP controller: state encoding, opcodes,
// IR capture pattern and the per-state decode flag bundle.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR,
    UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [3:0] OP_EXTEST         = 4'h0;
  localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'h1;
  localparam logic [3:0] OP_IDCODE         = 4'h2;
  localparam logic [3:0] OP_BYPASS         = 4'hF;

  // Low two bits of the IR capture value; upper bits are zero-filled.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  typedef struct packed {
    logic tlr;
    logic cap_dr;
    logic sh_dr;
    logic upd_dr;
    logic cap_ir;
    logic sh_ir;
    logic upd_ir;
  } tap_flags_t;

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Pin bundle between the TAP controller (master) and the test port / BSR chain.
// All signals are level-sampled on CK rising edge; there is no valid/ready handshake.
interface jtag_tap_ctrl_if #(parameter int IR_W = 4);
  import jtag_pkg::*;

  logic            TMS;
  logic            TDI;
  logic            TDO_BSR;
  logic            TDO;
  logic            tdo_oe;
  logic            clockdr;
  logic            updatedr;
  logic            shiftdr;
  logic            bs_en;
  logic [IR_W-1:0] ir_q;
  tap_state_t      state;

  modport master (
    input  TMS, TDI, TDO_BSR,
    output TDO, tdo_oe, clockdr, updatedr, shiftdr, bs_en, ir_q, state
  );

  modport slave (
    output TMS, TDI, TDO_BSR,
    input  TDO, tdo_oe, clockdr, updatedr, shiftdr, bs_en, ir_q, state
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP state machine; decode flags are registered alongside the
// state so they are glitch-free Moore outputs.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tms,
  output tap_state_t o_state,
  output tap_flags_t o_flags
);

  tap_state_t r_state;
  tap_flags_t r_flags;
  tap_state_t w_next;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PA_DR;
      PA_DR:   return tms ? EX2_DR : PA_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PA_IR;
      PA_IR:   return tms ? EX2_IR : PA_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      UPD_IR:  return tms ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  function automatic tap_flags_t tap_decode(input tap_state_t s);
    tap_flags_t f;
    f        = '0;
    f.tlr    = (s == TLR);
    f.cap_dr = (s == CAP_DR);
    f.sh_dr  = (s == SH_DR);
    f.upd_dr = (s == UPD_DR);
    f.cap_ir = (s == CAP_IR);
    f.sh_ir  = (s == SH_IR);
    f.upd_ir = (s == UPD_IR);
    return f;
  endfunction

  assign w_next = tap_next(r_state, i_tms);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= TLR;
      r_flags <= tap_decode(TLR);
    end else begin
      r_state <= w_next;
      r_flags <= tap_decode(w_next);
    end
  end

  assign o_state = r_state;
  assign o_flags = r_flags;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction/ID/bypass registers, BSR strobe gating and
// the TDO output mux around the jtag_tap_fsm state machine.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1923_4001
) (
  input  logic           CK,
  input  logic           TRST_N,
  jtag_tap_ctrl_if.master bus
);

  localparam logic [IR_W-1:0] IR_CAP_VAL = {{(IR_W-2){1'b0}}, IR_CAPTURE};

  tap_state_t      w_state;
  tap_flags_t      w_fl;
  logic [IR_W-1:0] r_ir_sr;
  logic [IR_W-1:0] r_ir_q;
  logic [31:0]     r_id;
  logic            r_bypass;
  logic [IR_W-1:0] w_ir_act;
  logic            w_sel_bsr;
  logic            w_sel_id;

  jtag_tap_fsm u_fsm (
    .i_clk   (CK),
    .i_rst_n (TRST_N),
    .i_tms   (bus.TMS),
    .o_state (w_state),
    .o_flags (w_fl)
  );

  // TLR forces IDCODE immediately, without waiting for the register to follow.
  assign w_ir_act  = w_fl.tlr ? IR_W'(OP_IDCODE) : r_ir_q;
  assign w_sel_bsr = (w_ir_act == IR_W'(OP_EXTEST)) || (w_ir_act == IR_W'(OP_SAMPLE_PRELOAD));
  assign w_sel_id  = (w_ir_act == IR_W'(OP_IDCODE));

  always_ff @(posedge CK) begin
    if (!TRST_N) begin
      r_ir_sr  <= '0;
      r_ir_q   <= IR_W'(OP_IDCODE);
      r_id     <= '0;
      r_bypass <= 1'b0;
    end else begin
      if (w_fl.cap_ir)
        r_ir_sr <= IR_CAP_VAL;
      else if (w_fl.sh_ir)
        r_ir_sr <= {bus.TDI, r_ir_sr[IR_W-1:1]};

      if (w_fl.tlr)
        r_ir_q <= IR_W'(OP_IDCODE);
      else if (w_fl.upd_ir)
        r_ir_q <= r_ir_sr;

      if (w_sel_id && w_fl.cap_dr)
        r_id <= IDCODE_VAL;
      else if (w_sel_id && w_fl.sh_dr)
        r_id <= {bus.TDI, r_id[31:1]};

      // Any opcode that selects neither the BSR nor the ID register uses bypass.
      if (!w_sel_bsr && !w_sel_id && w_fl.cap_dr)
        r_bypass <= 1'b0;
      else if (!w_sel_bsr && !w_sel_id && w_fl.sh_dr)
        r_bypass <= bus.TDI;
    end
  end

  assign bus.clockdr  = w_sel_bsr && (w_fl.cap_dr || w_fl.sh_dr);
  assign bus.shiftdr  = w_sel_bsr && w_fl.sh_dr;
  assign bus.updatedr = w_sel_bsr && w_fl.upd_dr;
  assign bus.bs_en    = (w_ir_act == IR_W'(OP_EXTEST));
  assign bus.tdo_oe   = w_fl.sh_dr || w_fl.sh_ir;
  assign bus.ir_q     = w_ir_act;
  assign bus.state    = w_state;

  always_comb begin
    bus.TDO = 1'b0;
    if (w_fl.sh_ir)
      bus.TDO = r_ir_sr[0];
    else if (w_fl.sh_dr)
      bus.TDO = w_sel_bsr ? bus.TDO_BSR : (w_sel_id ? r_id[0] : r_bypass);
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: TMS paths to every state, IDCODE
// readout, IR loads, an EXTEST DR scan, bypass with pause, and mid-shift reset.
module tb_jtag_tap_ctrl;
  import jtag_pkg::*;

  localparam int          IR_W   = 4;
  localparam logic [31:0] ID_VAL = 32'h1923_4001;

  logic CK;
  logic TRST_N;

  jtag_tap_ctrl_if #(.IR_W(IR_W)) jif ();

  jtag_tap_ctrl #(.IR_W(IR_W), .IDCODE_VAL(ID_VAL)) dut (
    .CK     (CK),
    .TRST_N (TRST_N),
    .bus    (jif.master)
  );

  // clock / reset
  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0h, expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // drivers
  task automatic step(input logic tms, input logic tdi);
    jif.TMS = tms;
    jif.TDI = tdi;
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    TRST_N = 1'b0;
    step(1'b1, 1'b0);
    TRST_N = 1'b1;
  endtask

  // From RTI: shift op into IR, leave via UPD_IR, end in RTI.
  task automatic load_ir(input logic [IR_W-1:0] op);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    exp_q.push_back(32'd1);
    for (int i = 1; i < IR_W; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < IR_W; i++) begin
      check_pop("ir_tdo", 32'(jif.TDO));
      step(i == IR_W - 1, op[i]);
    end
    step(1'b1, 1'b0);
    check("upd_ir_state", 32'(jif.state), 32'(UPD_IR));
    step(1'b0, 1'b0);
    check("ir_q_after_upd", 32'(jif.ir_q), 32'(op));
    check("bs_en_after_upd", 32'(jif.bs_en), 32'(op == 4'h0));
  endtask

  logic [7:0] path_bits [16];
  int         path_len  [16];
  int         strobe_hits;
  int         shift_ok;
  logic       b;

  initial begin
    path_bits = '{8'b0, 8'b0, 8'b10, 8'b010, 8'b0010, 8'b1010, 8'b01010, 8'b101010,
                  8'b11010, 8'b110, 8'b0110, 8'b00110, 8'b10110, 8'b010110,
                  8'b1010110, 8'b110110};
    path_len  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

    TRST_N      = 1'b1;
    jif.TMS     = 1'b1;
    jif.TDI     = 1'b0;
    jif.TDO_BSR = 1'b0;
    @(negedge CK);

    // reset state
    do_reset();
    check("rst_state", 32'(jif.state), 32'(TLR));
    check("rst_ir_q", 32'(jif.ir_q), 32'h2);
    check("rst_tdo", 32'(jif.TDO), 32'd0);
    check("rst_tdo_oe", 32'(jif.tdo_oe), 32'd0);
    check("rst_strobes", {29'd0, jif.clockdr, jif.shiftdr, jif.updatedr}, 32'd0);
    check("rst_bs_en", 32'(jif.bs_en), 32'd0);

    // every state, then five TMS=1 back to TLR
    for (int s = 0; s < 16; s++) begin
      do_reset();
      for (int k = 0; k < path_len[s]; k++) step(path_bits[s][k], 1'b0);
      check("path_state", 32'(jif.state), 32'(s));
      check("path_tdo_oe", 32'(jif.tdo_oe),
            32'(s == int'(SH_DR) || s == int'(SH_IR)));
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
      check("tlr5_state", 32'(jif.state), 32'(TLR));
      check("tlr5_ir_q", 32'(jif.ir_q), 32'h2);
      check("tlr5_bs_en", 32'(jif.bs_en), 32'd0);
    end

    // IDCODE readout after reset
    do_reset();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("id_cap_clockdr", 32'(jif.clockdr), 32'd0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(ID_VAL[i]));
    strobe_hits = 0;
    for (int i = 0; i < 32; i++) begin
      check_pop("id_tdo", 32'(jif.TDO));
      if (jif.clockdr || jif.shiftdr || jif.updatedr) strobe_hits++;
      step(i == 31, 1'($urandom_range(0, 1)));
    end
    check("id_exit_state", 32'(jif.state), 32'(EX1_DR));
    step(1'b1, 1'b0);
    if (jif.updatedr) strobe_hits++;
    check("id_strobes_quiet", 32'(strobe_hits), 32'd0);
    step(1'b0, 1'b0);

    // EXTEST and a 74-bit BSR scan
    load_ir(4'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("ext_cap_clockdr", 32'(jif.clockdr), 32'd1);
    check("ext_cap_shiftdr", 32'(jif.shiftdr), 32'd0);
    check("ext_cap_bs_en", 32'(jif.bs_en), 32'd1);
    step(1'b0, 1'b0);
    shift_ok = 0;
    for (int i = 0; i < 74; i++) begin
      b = 1'($urandom_range(0, 1));
      jif.TDO_BSR = b;
      exp_q.push_back(32'(b));
      #1;
      check_pop("ext_tdo", 32'(jif.TDO));
      if (jif.clockdr && jif.shiftdr && !jif.updatedr && jif.tdo_oe) shift_ok++;
      step(i == 73, 1'($urandom_range(0, 1)));
    end
    check("ext_shift_cycles", 32'(shift_ok), 32'd74);
    check("ext_ex1_clockdr", 32'(jif.clockdr), 32'd0);
    step(1'b1, 1'b0);
    check("ext_upd_updatedr", 32'(jif.updatedr), 32'd1);
    check("ext_upd_clockdr", 32'(jif.clockdr), 32'd0);
    step(1'b0, 1'b0);
    check("ext_rti_updatedr", 32'(jif.updatedr), 32'd0);

    // undefined opcode acts as bypass, with a pause mid-scan
    load_ir(4'h7);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("byp_cap_clockdr", 32'(jif.clockdr), 32'd0);
    step(1'b0, 1'b0);
    exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      b = (i != 1);
      check_pop("byp_tdo", 32'(jif.TDO));
      exp_q.push_back(32'(b));
      step(i == 3, b);
    end
    step(1'b0, 1'b0);
    check("pause_state", 32'(jif.state), 32'(PA_DR));
    check("pause_tdo_oe", 32'(jif.tdo_oe), 32'd0);
    check("pause_tdo", 32'(jif.TDO), 32'd0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("resume_state", 32'(jif.state), 32'(SH_DR));
    check_pop("byp_hold_tdo", 32'(jif.TDO));
    check("byp_queue_drained", 32'(exp_q.size()), 32'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // reset in the middle of an EXTEST shift
    load_ir(4'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("pre_trst_shiftdr", 32'(jif.shiftdr), 32'd1);
    TRST_N = 1'b0;
    step(1'b0, 1'b1);
    TRST_N = 1'b1;
    check("trst_state", 32'(jif.state), 32'(TLR));
    check("trst_strobes", {29'd0, jif.clockdr, jif.shiftdr, jif.updatedr}, 32'd0);
    check("trst_bs_en", 32'(jif.bs_en), 32'd0);
    check("trst_ir_q", 32'(jif.ir_q), 32'h2);
    check("trst_tdo_oe", 32'(jif.tdo_oe), 32'd0);
    step(1'b0, 1'b0);
    check("trst_rti_ir_q", 32'(jif.ir_q), 32'h2);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1-style TAP controller that drives the boundary-scan register chain wrapped around our ISCAS CUTs (s9234 first). It runs the 16-state TAP FSM from TMS and holds a 4-bit instruction register, a bypass bit and a 32-bit IDCODE register. It decodes the BSR strobes `clockdr`/`updatedr`/`shiftdr`/`bs_en` and muxes the chain's `TDO_BSR` back out to `TDO`. It is the initiator side of the scan-cell control interface the BSR wrappers consume.

## Interface
- `IR_W`, 4: instruction register width.
- `IDCODE_VAL`, 32'h1923_4001: value captured into the ID register; bit 0 must be 1.
- `CK` input 1: sole clock; all state updates on rising edge.
- `TRST_N` input 1: reset, synchronous, active-low.
- `TMS` input 1: TAP mode select, sampled on `CK` rising edge.
- `TDI` input 1: serial data in; also forwarded to the BSR chain head.
- `TDO_BSR` input 1: serial out of the BSR chain tail.
- `TDO` output 1: serial data out.
- `tdo_oe` output 1: high while in SHIFT_DR or SHIFT_IR.
- `clockdr` output 1: BSR capture/shift enable strobe.
- `updatedr` output 1: BSR update-latch enable strobe.
- `shiftdr` output 1: BSR serial/parallel select.
- `bs_en` output 1: BSR drives the CUT/pins from update latches.
- `ir_q` output `IR_W`: active (updated) instruction, for debug.

## Operation
- FSM states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR. Transitions follow the standard 1149.1 graph on `TMS`. Five consecutive `TMS`=1 reach TLR from any state.
- Opcodes: EXTEST 4'h0, SAMPLE_PRELOAD 4'h1, IDCODE 4'h2, BYPASS 4'hF. Any other opcode behaves as BYPASS.
- Instruction shift register: loads {`IR_W`-2 zeros, 2'b01} in CAP_IR. Shifts right in SH_IR, with `TDI` entering the MSB. Copied to `ir_q` in UPD_IR. `ir_q` is forced to IDCODE whenever the FSM is in TLR.
- Selected DR:
  - EXTEST/SAMPLE_PRELOAD selects the BSR.
  - IDCODE selects the ID register. It loads `IDCODE_VAL` in CAP_DR and shifts right with `TDI` entering bit 31 in SH_DR.
  - BYPASS selects the bypass bit. It loads 0 in CAP_DR and loads `TDI` in SH_DR.
- BSR strobes are Moore outputs decoded from the state register and are only active when the BSR is selected:
  - `clockdr`=1 in CAP_DR and SH_DR.
  - `shiftdr`=1 in SH_DR only.
  - `updatedr`=1 in UPD_DR only.
  - The BSR therefore captures when `clockdr`&!`shiftdr` and shifts when `clockdr`&`shiftdr`.
- `bs_en`=1 iff `ir_q`==EXTEST. It is 0 in TLR.
- `TDO` mux (combinational from registers and `TDO_BSR`):
  - SH_IR: instruction shift reg bit 0.
  - SH_DR: the selected DR's bit 0, or `TDO_BSR` when the BSR is selected.
  - All other states: 0.

## Timing
- Reset (`TRST_N`=0 at an edge): state TLR, `ir_q`=IDCODE, instruction shift reg=0, ID reg=0, bypass=0. All outputs 0 (`TDO`=0, `tdo_oe`=0).
- `TRST_N` low mid-shift aborts the shift at the next edge. Shift registers are cleared and `ir_q` is not updated from the partial shift.
- Strobes are asserted in the same cycle the FSM is in the decoding state, i.e. one cycle after the `TMS` edge that entered it. `updatedr` is exactly one cycle wide per UPD_DR visit.
- Shift of N bits: enter SH_DR, hold `TMS`=0 for N−1 cycles, then `TMS`=1 on the Nth shift. The last bit shifts on the SH_DR→EX1_DR edge.
- The new `ir_q` (and hence `bs_en`) takes effect the cycle after UPD_IR.
- `TDO` is valid in the same cycle as the SH_* state with no extra latency.
- Pausing (PA_DR/PA_IR) holds all shift registers unchanged, with all strobes and `tdo_oe` at 0.

## Structure
- Package `jtag_pkg`:
  - `tap_state_t` enum (4-bit encoding).
  - Opcode localparams.
  - `IR_CAPTURE` constant.
- One sub-module, `jtag_tap_fsm`: state register, next-state logic, and per-state decode flags.
- The top level holds the IR, ID register, bypass bit, strobe gating and `TDO` mux.

## Test plan
- Reset then 5×`TMS`=1 from each of the 16 states (forced via TMS paths) -> state TLR, `ir_q`=4'h2, `bs_en`=0.
- After reset, go to SH_DR and shift 32 bits -> `TDO` sequence = `IDCODE_VAL` LSB first (first bit 1). `clockdr`/`shiftdr`/`updatedr` stay 0 throughout.
- Load IR 4'h0 (TDI LSB-first 0,0,0,0) -> `TDO` during SH_IR = 1,0,0,0. `bs_en`=1 the cycle after UPD_IR.
- EXTEST DR scan of 74 bits:
  - CAP_DR gives `clockdr`=1, `shiftdr`=0 for 1 cycle.
  - Then 74 cycles with `clockdr`=`shiftdr`=1 and `TDO`=`TDO_BSR`.
  - UPD_DR gives a single-cycle `updatedr`.
- IR 4'h7 (undefined), then shift TDI pattern 1,0,1,1 -> `TDO` = 0,1,0,1 (1-bit bypass delay).
- `TRST_N`=0 for 1 cycle during an EXTEST SH_DR -> next cycle state TLR, all strobes 0, `bs_en`=0, `ir_q`=4'h2.
